// File: rtl/oc_pattern_gen.sv
// Enumerates every N-bit word whose popcount equals the requested count, in
// ascending order, over a valid/ready stream (inverse of the ones-counter cells).
module oc_pattern_gen #(
  parameter int N  = 3,
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CW-1:0] count,
  output logic          busy,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  pattern,
  output logic          done,
  output logic [N:0]    npat
);

  localparam int PW = (N + 1 > CW) ? N + 1 : CW;
  localparam logic [N-1:0] CAND_ONE = 1;
  localparam logic [N:0]   NPAT_ONE = 1;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_OUT, S_DONE} state_t;

  state_t        r_state;
  logic [CW-1:0] r_k;
  logic [N-1:0]  r_cand;
  logic [N:0]    r_npat;

  logic [N:0]    w_psum [0:N];
  logic          w_match;
  logic          w_last;

  // Running sum is N+1 bits wide, so even an all-ones word cannot overflow.
  assign w_psum[0] = '0;
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_pop
      assign w_psum[gi+1] = w_psum[gi] + {{N{1'b0}}, r_cand[gi]};
    end
  endgenerate

  assign w_match = (PW'(w_psum[N]) == PW'(r_k));
  assign w_last  = &r_cand;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_cand  <= '0;
      r_npat  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_k     <= count;
            r_cand  <= '0;
            r_npat  <= '0;
            r_state <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (w_match) begin
            r_state <= S_OUT;
          end else if (w_last) begin
            r_state <= S_DONE;
          end else begin
            r_cand <= r_cand + CAND_ONE;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            r_npat <= r_npat + NPAT_ONE;
            if (w_last) begin
              r_state <= S_DONE;
            end else begin
              r_cand  <= r_cand + CAND_ONE;
              r_state <= S_SCAN;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode registered state only; nothing combinational from inputs.
  assign busy      = (r_state != S_IDLE);
  assign out_valid = (r_state == S_OUT);
  assign done      = (r_state == S_DONE);
  assign pattern   = r_cand;
  assign npat      = r_npat;

endmodule

// File: tb/tb_oc_pattern_gen.sv
// Directed bench for oc_pattern_gen (N=3): word order, cycle timing, stalls,
// ignored re-start and mid-OUT reset.
module tb_oc_pattern_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] count = 2'd0;
  logic       out_ready = 1'b0;
  logic       busy;
  logic       out_valid;
  logic       done;
  logic [2:0] pattern;
  logic [3:0] npat;

  int checks = 0;
  int errors = 0;

  logic [2:0] words [$];
  int         wcyc  [$];
  int         done_rel;
  bit         saw_done;

  oc_pattern_gen #(.N(3), .CW(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .count     (count),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pattern   (pattern),
    .done      (done),
    .npat      (npat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a run with count k; rel=1 is the first cycle after the accepting edge.
  task automatic run(input logic [1:0] k, input int stall, input int repulse);
    int         sc;
    bit         holding;
    logic [2:0] held;
    sc = 0;
    holding = 1'b0;
    held = 3'd0;
    words.delete();
    wcyc.delete();
    saw_done = 1'b0;
    done_rel = -1;
    count = k;
    start = 1'b1;
    out_ready = (stall == 0);
    tick();
    start = 1'b0;
    for (int rel = 1; rel < 200; rel++) begin
      start = (rel == repulse);
      if (rel == repulse) count = 2'd3;
      if (done) begin
        saw_done = 1'b1;
        done_rel = rel;
        break;
      end
      if (out_valid) begin
        if (holding) chk("hold_stable", pattern, held);
        if (sc < stall) begin
          out_ready = 1'b0;
          sc++;
          holding = 1'b1;
          held = pattern;
        end else begin
          out_ready = 1'b1;
          words.push_back(pattern);
          wcyc.push_back(rel);
          sc = 0;
          holding = 1'b0;
        end
      end else begin
        if (holding) chk("valid_held", out_valid, 1'b1);
        out_ready = (stall == 0);
      end
      tick();
    end
    start = 1'b0;
    chk("done_seen", saw_done, 1'b1);
  endtask

  task automatic check_words(input string tag, input int n,
                             input logic [2:0] e0, input logic [2:0] e1, input logic [2:0] e2);
    logic [2:0] exp_w [3];
    exp_w[0] = e0;
    exp_w[1] = e1;
    exp_w[2] = e2;
    chk({tag, "_nwords"}, words.size(), n);
    for (int i = 0; i < n && i < words.size(); i++)
      chk($sformatf("%s_word%0d", tag, i), words[i], exp_w[i]);
  endtask

  // After done, the pulse must last one cycle and the block return to IDLE.
  task automatic check_after_done(input string tag, input logic [3:0] exp_npat);
    chk({tag, "_npat_at_done"}, npat, exp_npat);
    tick();
    chk({tag, "_done_one_cycle"}, done, 1'b0);
    chk({tag, "_idle_after_done"}, busy, 1'b0);
    chk({tag, "_npat_held"}, npat, exp_npat);
  endtask

  initial begin
    bit found;

    // Reset state
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_pattern", pattern, 3'd0);
    chk("rst_npat", npat, 4'd0);
    rst_n = 1'b1;
    tick();

    // k=0: single word 000
    run(2'd0, 0, 0);
    check_words("k0", 1, 3'b000, 3'b000, 3'b000);
    if (wcyc.size() > 0) chk("k0_valid_cycle", wcyc[0], 2);
    chk("k0_done_cycle", done_rel, 10);
    check_after_done("k0", 4'd1);

    // k=1: 001, 010, 100
    run(2'd1, 0, 0);
    check_words("k1", 3, 3'b001, 3'b010, 3'b100);
    if (wcyc.size() == 3) begin
      chk("k1_cyc0", wcyc[0], 3);
      chk("k1_cyc1", wcyc[1], 5);
      chk("k1_cyc2", wcyc[2], 8);
    end
    chk("k1_done_cycle", done_rel, 12);
    check_after_done("k1", 4'd3);

    // k=3: single word 111 found on the last candidate
    run(2'd3, 0, 0);
    check_words("k3", 1, 3'b111, 3'b111, 3'b111);
    if (wcyc.size() > 0) chk("k3_valid_cycle", wcyc[0], 9);
    chk("k3_done_cycle", done_rel, 10);
    check_after_done("k3", 4'd1);

    // k=2 with 5 stall cycles per word
    run(2'd2, 5, 0);
    check_words("k2stall", 3, 3'b011, 3'b101, 3'b110);
    check_after_done("k2stall", 4'd3);

    // k=1 with start re-pulsed (count=3) while busy
    run(2'd1, 0, 3);
    check_words("repulse", 3, 3'b001, 3'b010, 3'b100);
    chk("repulse_done_cycle", done_rel, 12);
    check_after_done("repulse", 4'd3);

    // Reset while OUT presents 010
    count = 2'd1;
    start = 1'b1;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (out_valid && pattern == 3'b010) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    out_ready = 1'b0;
    chk("rstmid_reached_010", found, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_valid", out_valid, 1'b0);
    chk("rstmid_done", done, 1'b0);
    chk("rstmid_pattern", pattern, 3'd0);
    chk("rstmid_npat", npat, 4'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rstmid_no_done", done, 1'b0);
      chk("rstmid_stay_idle", busy, 1'b0);
    end

    run(2'd2, 0, 0);
    check_words("post_rst_k2", 3, 3'b011, 3'b101, 3'b110);
    check_after_done("post_rst_k2", 4'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
